// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the NTT pointwise-multiply scheduler state type.
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int PAIRS   = KYBER_N / 2;
  localparam int CW      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ntt_mul_state_t;
endpackage

// File: rtl/base_case_multiply.sv
// Kyber base-case multiply of two degree-1 polynomials modulo (X^2 - gamma), all values in 0..q-1.
module base_case_multiply #(
  parameter int CW = kyber_pkg::CW
) (
  input  logic [CW-1:0] a0,
  input  logic [CW-1:0] a1,
  input  logic [CW-1:0] b0,
  input  logic [CW-1:0] b1,
  input  logic [CW-1:0] gamma,
  output logic [CW-1:0] c0,
  output logic [CW-1:0] c1
);
  localparam logic [31:0] Q = 32'(kyber_pkg::KYBER_Q);

  logic [31:0] p00, p11, p01, p10, p11_red, p11_g;

  always_comb begin
    p00     = 32'(a0) * 32'(b0);
    p11     = 32'(a1) * 32'(b1);
    p01     = 32'(a0) * 32'(b1);
    p10     = 32'(a1) * 32'(b0);
    // Reduce a1*b1 before scaling by gamma so the product stays within 32 bits.
    p11_red = p11 % Q;
    p11_g   = p11_red * 32'(gamma);
    c0      = CW'(((p00 % Q) + (p11_g % Q)) % Q);
    c1      = CW'(((p01 % Q) + (p10 % Q)) % Q);
  end
endmodule

// File: rtl/ntt_mul_scheduler.sv
// Streams all coefficient pairs of f and g through one shared base_case_multiply,
// three-stage pipeline (issue / operand register / result register) with a global stall.
module ntt_mul_scheduler #(
  parameter int PAIRS = kyber_pkg::PAIRS,
  parameter int CW    = kyber_pkg::CW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stall,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(PAIRS)-1:0]   f_addr,
  output logic [$clog2(PAIRS)-1:0]   g_addr,
  output logic [$clog2(PAIRS)-1:0]   z_addr,
  output logic                       rd_en,
  input  logic [2*CW-1:0]            f_rdata,
  input  logic [2*CW-1:0]            g_rdata,
  input  logic [CW-1:0]              z_rdata,
  output logic [$clog2(PAIRS)-1:0]   h_addr,
  output logic [2*CW-1:0]            h_wdata,
  output logic                       h_we,
  output kyber_pkg::ntt_mul_state_t  state_dbg
);
  import kyber_pkg::*;

  localparam int AW = $clog2(PAIRS);
  localparam logic [AW-1:0] LAST = AW'(PAIRS - 1);

  // Handshake: there is none on the data path; memories answer one cycle after
  // rd_en, and stall=1 freezes every register while suppressing rd_en and h_we.
  ntt_mul_state_t state, state_nxt;
  logic [AW-1:0]  cnt;
  logic           issue;
  logic           s0_v, s1_v, s2_v;
  logic [AW-1:0]  s0_idx, s1_idx;
  logic [CW-1:0]  a0, a1, b0, b1, gamma;
  logic [CW-1:0]  c0, c1;

  assign issue = (state == RUN) && !stall;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && cnt == LAST) state_nxt = DRAIN;
      DRAIN:   if (s2_v && h_addr == LAST && !stall) state_nxt = DONE;
      DONE:    if (!stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN) || (state == DRAIN);
    done  = (state == DONE) && !stall;
    rd_en = issue;
  end

  always_ff @(posedge clk) begin
    if (rst)        cnt <= '0;
    else if (issue) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  // Operand and result registers only load behind a valid stage, so h_addr
  // and h_wdata keep the last written pair once the pipeline empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v    <= 1'b0;
      s0_idx  <= '0;
      s1_v    <= 1'b0;
      s1_idx  <= '0;
      a0      <= '0;
      a1      <= '0;
      b0      <= '0;
      b1      <= '0;
      gamma   <= '0;
      s2_v    <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
    end else if (!stall) begin
      s0_v   <= issue;
      s0_idx <= cnt;
      s1_v   <= s0_v;
      s2_v   <= s1_v;
      if (s0_v) begin
        s1_idx <= s0_idx;
        a0     <= f_rdata[CW-1:0];
        a1     <= f_rdata[2*CW-1:CW];
        b0     <= g_rdata[CW-1:0];
        b1     <= g_rdata[2*CW-1:CW];
        gamma  <= z_rdata;
      end
      if (s1_v) begin
        h_addr  <= s1_idx;
        h_wdata <= {c1, c0};
      end
    end
  end

  base_case_multiply #(.CW(CW)) u_bcm (
    .a0    (a0),
    .a1    (a1),
    .b0    (b0),
    .b1    (b1),
    .gamma (gamma),
    .c0    (c0),
    .c1    (c1)
  );

  assign h_we      = s2_v && !stall;
  assign f_addr    = cnt;
  assign g_addr    = cnt;
  assign z_addr    = cnt;
  assign state_dbg = state;
endmodule

// File: tb/tb_ntt_mul_scheduler.sv
// Directed-sequence bench for ntt_mul_scheduler with RAM/ROM models and a pointwise-product reference.
module tb_ntt_mul_scheduler;
  import kyber_pkg::*;

  localparam int NP = 128;
  localparam int QM = 3329;

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic        busy, done, rd_en, h_we;
  logic [6:0]  f_addr, g_addr, z_addr, h_addr;
  logic [31:0] f_rdata, g_rdata, h_wdata;
  logic [15:0] z_rdata;
  ntt_mul_state_t state_dbg;

  always #5 clk = ~clk;

  ntt_mul_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done),
    .f_addr(f_addr), .g_addr(g_addr), .z_addr(z_addr), .rd_en(rd_en),
    .f_rdata(f_rdata), .g_rdata(g_rdata), .z_rdata(z_rdata),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_we(h_we), .state_dbg(state_dbg)
  );

  logic [15:0] f_mem [256];
  logic [15:0] g_mem [256];
  logic [15:0] z_mem [128];

  always @(posedge clk) begin
    if (rd_en) begin
      f_rdata <= {f_mem[2*int'(f_addr)+1], f_mem[2*int'(f_addr)]};
      g_rdata <= {g_mem[2*int'(g_addr)+1], g_mem[2*int'(g_addr)]};
      z_rdata <= z_mem[int'(z_addr)];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_data_q[$];
  int          wr_addr_q[$];
  int          wr_cyc_q[$];
  int          done_cnt, done_cyc, we_stall, busy_first, busy_last;

  always @(negedge clk) begin
    if (h_we) begin
      wr_addr_q.push_back(int'(h_addr));
      wr_data_q.push_back(h_wdata);
      wr_cyc_q.push_back(cyc);
      if (stall) we_stall++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pointwise product in Z_q[X]/(X^2 - gamma_j), straight from the definition.
  task automatic build_expected();
    longint x0, x1, y0, y1, z, r0, r1;
    exp_q.delete();
    for (int j = 0; j < NP; j++) begin
      x0 = f_mem[2*j]; x1 = f_mem[2*j+1];
      y0 = g_mem[2*j]; y1 = g_mem[2*j+1];
      z  = z_mem[j];
      r0 = (x0 * y0 + x1 * y1 * z) % QM;
      r1 = (x0 * y1 + x1 * y0) % QM;
      exp_q.push_back({16'(r1), 16'(r0)});
    end
  endtask

  // 0: zero f/g, 1: f0=g0=1, 2: f1=g1=1, 3: random, 4: all q-1
  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        3:       begin f_mem[i] = 16'($urandom_range(0, QM-1)); g_mem[i] = 16'($urandom_range(0, QM-1)); end
        4:       begin f_mem[i] = 16'(QM-1); g_mem[i] = 16'(QM-1); end
        default: begin f_mem[i] = 16'd0; g_mem[i] = 16'd0; end
      endcase
    end
    for (int j = 0; j < NP; j++)
      z_mem[j] = (mode == 4) ? 16'(QM-1) : 16'($urandom_range(0, QM-1));
    if (mode == 1) begin f_mem[0] = 16'd1; g_mem[0] = 16'd1; z_mem[0] = 16'd17; end
    if (mode == 2) begin f_mem[1] = 16'd1; g_mem[1] = 16'd1; z_mem[0] = 16'd17; end
  endtask

  function automatic logic stalled(input int mode, input int off);
    return (mode == 1) && (off == 0 || (off >= 50 && off <= 54) || (off >= 131 && off <= 133));
  endfunction

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; we_stall = 0; busy_first = -1; busy_last = -1;
  endtask

  // Called at posedge+1 of the cycle in which start is to be sampled.
  task automatic run_op(input string tag, input int smode, input bit extra_start, input int exp_done);
    int s, t, off, n;
    build_expected();
    clear_log();
    s = cyc;
    start = 1'b1;
    stall = stalled(smode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 400) begin
      off   = cyc - s;
      stall = stalled(smode, off);
      start = extra_start && (off == 10 || off == 131);
      @(posedge clk); #1;
      t++;
    end
    stall = 1'b0;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_offset"}, 32'(done_cyc - s), 32'(exp_done));
    chk({tag, "_write_count"}, 32'(wr_addr_q.size()), 32'd128);
    chk({tag, "_busy_first"}, 32'(busy_first - s), 32'd1);
    chk({tag, "_busy_last"}, 32'(busy_last - s), 32'(exp_done - 1));
    chk({tag, "_we_during_stall"}, 32'(we_stall), 32'd0);
    chk({tag, "_idle_after"}, 32'(state_dbg), 32'(IDLE));
    n = wr_addr_q.size();
    if (n > 0) begin
      chk({tag, "_first_write_offset"}, 32'(wr_cyc_q[0] - s), 32'd4);
      chk({tag, "_last_write_offset"}, 32'(wr_cyc_q[n-1] - s), 32'(exp_done - 1));
    end
    for (int i = 0; i < n && i < NP; i++) begin
      chk($sformatf("%s_h_addr_%0d", tag, i), 32'(wr_addr_q[i]), 32'(i));
      chk($sformatf("%s_h_wdata_%0d", tag, i), wr_data_q[i], exp_q[i]);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_h_we"}, 32'(h_we), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_h_addr"}, 32'(h_addr), 32'd0);
    chk({tag, "_h_wdata"}, h_wdata, 32'd0);
    chk({tag, "_f_addr"}, 32'(f_addr), 32'd0);
    chk({tag, "_z_addr"}, 32'(z_addr), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    clear_log();
    fill(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    fill(0);
    run_op("zero", 0, 1'b0, 132);

    fill(1);
    run_op("unit0", 0, 1'b0, 132);
    chk("unit0_pair0", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxx_xxxx, 32'h0000_0001);

    fill(2);
    run_op("unit1", 0, 1'b0, 132);
    chk("unit1_pair0", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxx_xxxx, 32'h0000_0011);

    fill(3);
    run_op("rand_a", 0, 1'b0, 132);
    fill(4);
    run_op("max_val", 0, 1'b0, 132);

    fill(3);
    run_op("stall", 1, 1'b0, 140);

    fill(3);
    run_op("restart_ign", 0, 1'b1, 132);

    // Abort a run with reset, then a clean run two cycles later.
    fill(3);
    s = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc - s < 60) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy_set", 32'(busy_first >= 0), 32'd1);
    @(negedge clk);
    chk_quiet("after_rst");
    clear_log();
    @(posedge clk); #1;
    fill(3);
    run_op("post_rst", 0, 1'b0, 132);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntt_mul_scheduler.md
# ntt_mul_scheduler

Sequences the full 256-coefficient NTT-domain pointwise multiplication h = f ∘ g through a single shared `base_case_multiply` unit, one coefficient pair per cycle. Operands come from synchronous-read coefficient RAMs and a gamma ROM, and results go to an output RAM. It replaces the 128-instance fully parallel multiplier in area-constrained Kyber-768 builds. It sits between the polynomial RAM bank and the top-level Kyber control FSM, which drives `start` and waits for `done`.

## Interface
Parameters:
- PAIRS, 128, number of coefficient pairs (N/2); fixes the pair counter width at 7 bits
- CW, 16, coefficient width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a multiplication; sampled only in IDLE
- stall  in  1  freeze the whole pipeline for this cycle
- busy  out  1  high from the first RUN cycle through the last write
- done  out  1  one-cycle pulse after the last write
- f_addr, g_addr, z_addr  out  7  pair index j for the f RAM, g RAM and gamma ROM
- rd_en  out  1  read enable shared by the f, g and gamma memories
- f_rdata, g_rdata  in  32  {coef[2j+1], coef[2j]}, valid the cycle after rd_en
- z_rdata  in  16  gamma[j], valid the cycle after rd_en
- h_addr  out  7  pair index being written
- h_wdata  out  32  {c1, c0}
- h_we  out  1  write strobe for the h RAM

## Operation
- FSM states:
  - IDLE: start=1 → RUN.
  - RUN: issue counter 0..127; after issuing 127 → DRAIN.
  - DRAIN: wait until write of pair 127 is done → DONE.
  - DONE: pulse `done` for one cycle → IDLE.
- `start` outside IDLE is ignored; it is neither queued nor a restart.
- Three-stage pipeline, each stage with a valid bit and a pair index:
  - S0: address issue.
  - S1: memory read data arrives and is registered into a0,a1,b0,b1,gamma.
  - S2: combinational `base_case_multiply` output is registered into h_wdata, with h_we = S2 valid.
- Arithmetic is entirely inside `base_case_multiply`: c0 = a0·b0 + a1·b1·gamma mod 3329, c1 = a0·b1 + a1·b0 mod 3329. Inputs and outputs are canonical in 0..3328. No reduction happens in this block.
- `stall`=1 behaviour:
  - All state, counters, valid bits and data registers hold.
  - rd_en=0, so the RAMs hold their rdata.
  - h_we is forced to 0; h_addr and h_wdata hold.
  - `done` is never emitted on a stalled cycle; it is deferred.
  - `stall` in IDLE has no effect; start is still accepted.
- `rst` in any state → IDLE on the next edge. All valid bits clear, so no h_we occurs after reset and partial results are abandoned.
- Reset values: busy=0, done=0, h_we=0, rd_en=0, all address outputs 0, h_wdata=0.

## Timing
Unstalled, with start sampled in IDLE at cycle S:
- S+1: RUN, rd_en=1, addresses = 0.
- S+1+j: addresses = j, for j = 0..127.
- S+2+j: rdata for pair j is valid.
- S+4+j: h_we=1, h_addr=j, h_wdata = result for pair j.
- Last write at S+131; done=1 and busy=0 at S+132; IDLE at S+133. A new start is accepted at S+133 or later.
- busy is high S+1..S+131; latency from start to done is 132 cycles.
- Each stalled cycle adds exactly one cycle to every later event.
- h_we is never high on two cycles with the same h_addr. Writes are strictly ascending 0..127 with no gaps in the unstalled case.

## Structure
- Shared package `kyber_pkg` holds KYBER_Q=3329, KYBER_N=256, PAIRS, CW, and the `ntt_mul_state_t` enum {IDLE, RUN, DRAIN, DONE}.
- `base_case_multiply` is instantiated once as the sub-module. It has the existing port list (a0,a1,b0,b1,gamma,c0,c1) and is not modified.
- The FSM, issue counter and pipeline registers live in this module. There is no further sub-module.

## Test plan
- f=g=all zero, gamma arbitrary, start → 128 writes of h_wdata=0 at S+4..S+131; done at S+132.
- f[0]=1, g[0]=1, rest 0, gamma[0]=17 → h pair 0 = {0,1}, all other pairs 0. Then f[1]=g[1]=1 only → pair 0 = {0,17}.
- Random f, g, gamma in 0..3328 → all 256 h coefficients match a software reference; h_addr is ascending.
- stall high for 5 cycles at S+50 and 3 cycles at S+131 → no h_we while stalled, no lost or duplicated pairs, done at S+140.
- start pulsed at S+10 and S+131 → ignored; exactly 128 writes and a single done.
- rst asserted at S+60 → next cycle busy=0 and h_we=0. A start 2 cycles later runs a full clean 132-cycle operation.
